// File: rtl/aclk_entry_ctrl.sv
// Key-entry controller for the digital watch: sequences TIME/ALARM digit entry with timeout and abort.
// Define ACLK_RANGE_CHECK_EN to enforce HH:MM digit limits when NUM_DIGITS == 4.
module aclk_entry_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int TIMEOUT_SEC = 10,
  localparam int DW = $clog2(NUM_DIGITS + 1),
  localparam int TW = $clog2(TIMEOUT_SEC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          one_second,
  input  logic          time_button,
  input  logic          alarm_button,
  input  logic [3:0]    key,
  input  logic          key_valid,
  output logic          shift,
  output logic          load_new_c,
  output logic          load_new_a,
  output logic          reset_count,
  output logic          show_a,
  output logic          show_current_time,
  output logic [DW-1:0] digit_count,
  output logic          entry_error,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ENTRY, READY} state_e;
  typedef enum logic {MODE_TIME, MODE_ALARM} mode_e;

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          time_prev_q, alarm_prev_q;
  logic          shift_q, shift_d;
  logic          load_c_q, load_c_d;
  logic          load_a_q, load_a_d;
  logic          err_q, err_d;

  logic time_edge, alarm_edge, mode_edge;
  logic digit_ok, range_ok, timeout_hit;

  assign time_edge   = time_button & ~time_prev_q;
  assign alarm_edge  = alarm_button & ~alarm_prev_q;
  assign mode_edge   = (mode_q == MODE_ALARM) ? alarm_edge : time_edge;
  // Fires on the tick that would bring the timer up to TIMEOUT_SEC.
  assign timeout_hit = one_second & (timer_q >= TW'(TIMEOUT_SEC - 1));
  assign digit_ok    = (key <= 4'd9) & range_ok;

`ifdef ACLK_RANGE_CHECK_EN
  logic [3:0] d0_q;

  always_comb begin
    range_ok = 1'b1;
    if (NUM_DIGITS == 4) begin
      case (int'(count_q))
        0:       range_ok = (key <= 4'd2);
        1:       range_ok = (d0_q != 4'd2) || (key <= 4'd3);
        2:       range_ok = (key <= 4'd5);
        default: range_ok = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_q <= '0;
    end else if (shift_d && (count_q == '0)) begin
      d0_q <= key;
    end
  end
`else
  assign range_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    timer_d  = timer_q;
    shift_d  = 1'b0;
    load_c_d = 1'b0;
    load_a_d = 1'b0;
    err_d    = 1'b0;

    if ((state_q != IDLE) && one_second && (timer_q != TW'(TIMEOUT_SEC)))
      timer_d = timer_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (time_edge) begin
          state_d = ENTRY;
          mode_d  = MODE_TIME;
          count_d = '0;
          timer_d = '0;
        end else if (alarm_edge) begin
          state_d = ENTRY;
          mode_d  = MODE_ALARM;
          count_d = '0;
          timer_d = '0;
        end
      end
      ENTRY: begin
        if (mode_edge) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (key_valid && !digit_ok) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (key_valid) begin
          shift_d = 1'b1;
          count_d = count_q + 1'b1;
          timer_d = '0;
          if (count_q == DW'(NUM_DIGITS - 1))
            state_d = READY;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      READY: begin
        if (mode_edge) begin
          if (mode_q == MODE_TIME) load_c_d = 1'b1;
          else                     load_a_d = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any return to IDLE wipes the entry progress in the same transition.
    if (state_d == IDLE) begin
      count_d = '0;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_TIME;
      count_q      <= '0;
      timer_q      <= '0;
      time_prev_q  <= 1'b1;
      alarm_prev_q <= 1'b1;
      shift_q      <= 1'b0;
      load_c_q     <= 1'b0;
      load_a_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      time_prev_q  <= time_button;
      alarm_prev_q <= alarm_button;
      shift_q      <= shift_d;
      load_c_q     <= load_c_d;
      load_a_q     <= load_a_d;
      err_q        <= err_d;
    end
  end

  assign shift             = shift_q;
  assign load_new_c        = load_c_q;
  assign reset_count       = load_c_q;
  assign load_new_a        = load_a_q;
  assign entry_error       = err_q;
  assign digit_count       = count_q;
  assign busy              = (state_q != IDLE);
  assign show_a            = (busy & (mode_q == MODE_ALARM)) | ((state_q == IDLE) & alarm_button);
  assign show_current_time = ~show_a;

endmodule

// File: tb/tb_aclk_entry_ctrl.sv
// Self-checking bench for aclk_entry_ctrl: directed test-plan steps followed by a random phase,
// all compared against a digit-queue reference model of the entry rules.
module tb_aclk_entry_ctrl;

  localparam int ND = 4;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset, one_second, time_button, alarm_button, key_valid;
  logic [3:0] key;
  logic       shift, load_new_c, load_new_a, reset_count;
  logic       show_a, show_current_time, entry_error, busy;
  logic [2:0] digit_count;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model: an entry is a queue of accepted digits plus a seconds-idle counter.
  bit mActive, mAlarm, mPrevT, mPrevA;
  int mDigits[$];
  int mTicks;
  bit eShift, eLoadC, eLoadA, eErr;

  aclk_entry_ctrl #(.NUM_DIGITS(ND), .TIMEOUT_SEC(TO)) dut (
    .clk(clk),
    .reset(reset),
    .one_second(one_second),
    .time_button(time_button),
    .alarm_button(alarm_button),
    .key(key),
    .key_valid(key_valid),
    .shift(shift),
    .load_new_c(load_new_c),
    .load_new_a(load_new_a),
    .reset_count(reset_count),
    .show_a(show_a),
    .show_current_time(show_current_time),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit digitOk(input int k);
    int lim;
    lim = 9;
`ifdef ACLK_RANGE_CHECK_EN
    if (ND == 4) begin
      case (mDigits.size())
        0: lim = 2;
        1: lim = (mDigits[0] == 2) ? 3 : 9;
        2: lim = 5;
        default: lim = 9;
      endcase
    end
`endif
    return k <= lim;
  endfunction

  function automatic void modelStep(input bit rst, input bit sec, input bit tb, input bit ab,
                                    input logic [3:0] k, input bit kv);
    bit tEdge, aEdge, modeEdge, full;
    eShift = 0; eLoadC = 0; eLoadA = 0; eErr = 0;
    if (rst) begin
      mActive = 0; mAlarm = 0; mDigits.delete(); mTicks = 0; mPrevT = 1; mPrevA = 1;
      return;
    end
    tEdge  = tb && !mPrevT;
    aEdge  = ab && !mPrevA;
    mPrevT = tb;
    mPrevA = ab;
    if (!mActive) begin
      if (tEdge || aEdge) begin
        mActive = 1; mAlarm = !tEdge; mDigits.delete(); mTicks = 0;
      end
    end else begin
      modeEdge = mAlarm ? aEdge : tEdge;
      full     = (mDigits.size() == ND);
      if (modeEdge) begin
        if (!full)       eErr   = 1;
        else if (mAlarm) eLoadA = 1;
        else             eLoadC = 1;
        mActive = 0;
      end else if (kv && !full) begin
        if (digitOk(int'(k))) begin
          mDigits.push_back(int'(k)); mTicks = 0; eShift = 1;
        end else begin
          eErr = 1; mActive = 0;
        end
      end else if (sec) begin
        mTicks++;
        if (mTicks >= TO) begin
          eErr = 1; mActive = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("shift", shift, eShift);
    chk("load_new_c", load_new_c, eLoadC);
    chk("reset_count", reset_count, eLoadC);
    chk("load_new_a", load_new_a, eLoadA);
    chk("entry_error", entry_error, eErr);
    chk("busy", busy, mActive);
    chk("digit_count", digit_count, mActive ? mDigits.size() : 0);
    chk("show_a", show_a, (mActive && mAlarm) || (!mActive && alarm_button));
    chk("show_current_time", show_current_time, !((mActive && mAlarm) || (!mActive && alarm_button)));
  endtask

  task automatic applyStimulus(input bit rst, input bit sec, input bit tb, input bit ab,
                               input logic [3:0] k, input bit kv);
    reset = rst; one_second = sec; time_button = tb; alarm_button = ab;
    key = k; key_valid = kv;
    modelStep(rst, sec, tb, ab, k, kv);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic keyIn(input logic [3:0] k);
    applyStimulus(0, 0, 0, 0, k, 1);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
  endtask

  task automatic pressTime();
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
  endtask

  task automatic pressAlarm();
    applyStimulus(0, 0, 0, 1, 4'd0, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
  endtask

  initial begin
    bit rTb, rAb;
    reset = 1; one_second = 0; time_button = 0; alarm_button = 0; key = 0; key_valid = 0;

    applyStimulus(1, 0, 0, 0, 4'd0, 0);
    applyStimulus(1, 0, 0, 0, 4'd0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_show_time", show_current_time, 1);
    chk("rst_count", digit_count, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);

    $display("[TB] time set");
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    chk("tset_busy", busy, 1);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    applyStimulus(0, 0, 0, 0, 4'd1, 1);
    chk("tset_shift", shift, 1);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    keyIn(4'd2); keyIn(4'd3); keyIn(4'd0);
    chk("tset_count", digit_count, 4);
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    chk("tset_loadc", load_new_c, 1);
    chk("tset_rstcnt", reset_count, 1);
    chk("tset_idle", busy, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    chk("tset_loadc_once", load_new_c, 0);

    $display("[TB] alarm set");
    applyStimulus(0, 0, 0, 1, 4'd0, 0);
    chk("aset_show_a", show_a, 1);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    keyIn(4'd0); keyIn(4'd6); keyIn(4'd4); keyIn(4'd5);
    applyStimulus(0, 0, 0, 1, 4'd0, 0);
    chk("aset_loada", load_new_a, 1);
    chk("aset_no_loadc", load_new_c, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    chk("aset_show_time", show_current_time, 1);

    $display("[TB] timeout");
    pressAlarm();
    keyIn(4'd3);
    for (int i = 1; i <= TO; i++) begin
      applyStimulus(0, 1, 0, 0, 4'd0, 0);
      chk("tout_err", entry_error, (i == TO) ? 1 : 0);
    end
    chk("tout_count", digit_count, 0);
    chk("tout_idle", busy, 0);
    pressAlarm();
    keyIn(4'd3);
    for (int i = 1; i < TO; i++) applyStimulus(0, 1, 0, 0, 4'd0, 0);
    applyStimulus(0, 1, 0, 0, 4'd5, 1);
    chk("tout_key_wins", shift, 1);
    chk("tout_no_err", entry_error, 0);
    chk("tout_count2", digit_count, 2);
    pressAlarm();

    $display("[TB] abort and invalid key");
    pressTime();
    applyStimulus(0, 0, 0, 0, 4'hB, 1);
    chk("bad_err", entry_error, 1);
    chk("bad_no_shift", shift, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    pressTime();
    keyIn(4'd1); keyIn(4'd2);
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    chk("cancel_err", entry_error, 1);
    chk("cancel_no_load", load_new_c, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);

    $display("[TB] simultaneous edges and reset");
    applyStimulus(0, 0, 1, 1, 4'd0, 0);
    chk("both_busy", busy, 1);
    chk("both_time_mode", show_a, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    pressTime();
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    applyStimulus(0, 0, 1, 0, 4'd1, 1);
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    applyStimulus(0, 0, 1, 0, 4'd2, 1);
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    chk("mid_count", digit_count, 2);
    applyStimulus(1, 0, 1, 0, 4'd0, 0);
    applyStimulus(1, 0, 1, 0, 4'd0, 0);
    chk("rst_mid_idle", busy, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 4'd0, 0);
    chk("rst_held_no_entry", busy, 0);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);

`ifdef ACLK_RANGE_CHECK_EN
    $display("[TB] range check");
    pressTime();
    keyIn(4'd2);
    applyStimulus(0, 0, 0, 0, 4'd4, 1);
    chk("range_err", entry_error, 1);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
    pressTime();
    keyIn(4'd1); keyIn(4'd9); keyIn(4'd5); keyIn(4'd9);
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    chk("range_loadc", load_new_c, 1);
    applyStimulus(0, 0, 0, 0, 4'd0, 0);
`endif

    $display("[TB] random phase");
    rTb = 0; rAb = 0;
    for (int n = 0; n < 1500; n++) begin
      bit rRst, rSec, rKv;
      logic [3:0] rKey;
      if ($urandom_range(0, 5) == 0) rTb = !rTb;
      if ($urandom_range(0, 5) == 0) rAb = !rAb;
      rRst = ($urandom_range(0, 199) == 0);
      rSec = ($urandom_range(0, 3) == 0);
      rKv  = ($urandom_range(0, 2) == 0);
      rKey = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      applyStimulus(rRst, rSec, rTb, rAb, rKey, rKv);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
